// File: rtl/ex_stage_mdu_if.sv
// rtl/ex_stage_mdu_if.sv - ID/EX input bundle and EX/MEM output bundle of the execute stage
interface ex_stage_mdu_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int AOPW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rd1;
    logic [XLEN-1:0] in_rd2;
    logic [RAW-1:0]  in_rt;
    logic [RAW-1:0]  in_rd;
    logic [RAW-1:0]  in_shamt;
    logic [XLEN-1:0] in_imm;
    logic            in_regdst;
    logic            in_alusrca;
    logic            in_alusrcb;
    logic            in_regwrite;
    logic            in_memread;
    logic            in_memwrite;
    logic            in_memtoreg;
    logic [3:0]      in_loadtype;
    logic [2:0]      in_savetype;
    logic [AOPW-1:0] in_aluop;
    logic [2:0]      in_mdop;

    logic            out_valid;
    logic            out_ready;
    logic            out_regwrite;
    logic            out_memread;
    logic            out_memwrite;
    logic            out_memtoreg;
    logic [RAW-1:0]  out_wa;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_wdata;
    logic [3:0]      out_loadtype;
    logic [2:0]      out_savetype;

    modport slave (
        input  in_valid, in_rd1, in_rd2, in_rt, in_rd, in_shamt, in_imm,
               in_regdst, in_alusrca, in_alusrcb, in_regwrite, in_memread,
               in_memwrite, in_memtoreg, in_loadtype, in_savetype, in_aluop,
               in_mdop, out_ready,
        output in_ready, out_valid, out_regwrite, out_memread, out_memwrite,
               out_memtoreg, out_wa, out_result, out_wdata, out_loadtype,
               out_savetype
    );

    modport master (
        output in_valid, in_rd1, in_rd2, in_rt, in_rd, in_shamt, in_imm,
               in_regdst, in_alusrca, in_alusrcb, in_regwrite, in_memread,
               in_memwrite, in_memtoreg, in_loadtype, in_savetype, in_aluop,
               in_mdop, out_ready,
        input  in_ready, out_valid, out_regwrite, out_memread, out_memwrite,
               out_memtoreg, out_wa, out_result, out_wdata, out_loadtype,
               out_savetype
    );
endinterface

// File: rtl/ex_stage_mdu.sv
// rtl/ex_stage_mdu.sv - execute stage with EX/MEM register, forwarding and optional MDU (EX_MDU_EN)
module alu #(
    parameter int XLEN = 32,
    parameter int AOPW = 5
) (
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    input  logic [AOPW-1:0] alu_op,
    output logic [XLEN-1:0] alu_out
);
    localparam int SW = $clog2(XLEN);

    always_comb begin
        alu_out = '0;
        case (alu_op)
            AOPW'(0):  alu_out = alu_a + alu_b;
            AOPW'(1):  alu_out = alu_a - alu_b;
            AOPW'(2):  alu_out = alu_a & alu_b;
            AOPW'(3):  alu_out = alu_a | alu_b;
            AOPW'(4):  alu_out = alu_a ^ alu_b;
            AOPW'(5):  alu_out = ~(alu_a | alu_b);
            AOPW'(6):  alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            AOPW'(7):  alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            AOPW'(8):  alu_out = alu_b << alu_a[SW-1:0];
            AOPW'(9):  alu_out = alu_b >> alu_a[SW-1:0];
            AOPW'(10): alu_out = XLEN'($signed(alu_b) >>> alu_a[SW-1:0]);
            AOPW'(11): alu_out = {alu_b[XLEN/2-1:0], {(XLEN/2){1'b0}}};
            default:   alu_out = '0;
        endcase
    end
endmodule

module ex_stage_mdu #(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int AOPW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_stage_mdu_if.slave     bus,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              mdu_busy
);
    logic [XLEN-1:0] fa, fb, alu_a, alu_b, alu_out, ex_result, done_result;
    logic            accept, start_mdu, done_emit, ex_regwrite;

    always_comb begin
        fa = bus.in_rd1;
        case (fwd_a)
            2'b01:   fa = wb_data;
            2'b10:   fa = bus.out_result;
            default: fa = bus.in_rd1;
        endcase
        fb = bus.in_rd2;
        case (fwd_b)
            2'b01:   fb = wb_data;
            2'b10:   fb = bus.out_result;
            default: fb = bus.in_rd2;
        endcase
    end

    assign alu_a = bus.in_alusrca ? {{(XLEN-RAW){1'b0}}, bus.in_shamt} : fa;
    assign alu_b = bus.in_alusrcb ? bus.in_imm : fb;

    alu #(.XLEN(XLEN), .AOPW(AOPW)) u_alu (
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (bus.in_aluop),
        .alu_out(alu_out)
    );

    assign bus.in_ready = !mdu_busy && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready && !flush;

`ifdef EX_MDU_EN
    localparam int CW = $clog2(XLEN + 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] acc_q, qr_q, b_q, dvd_q, hi_q, lo_q, fin_hi, fin_lo;
    logic            is_div_q, neg_hi_q, neg_lo_q, dz_q;
    logic            signed_op, is_div_in, sa, sb, hilo_wr, mt_acc;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN:0]   sum, rem_sh, diff;

    assign start_mdu = accept && (bus.in_mdop >= 3'd1) && (bus.in_mdop <= 3'd4);
    assign mt_acc    = accept && (bus.in_mdop == 3'd7);
    assign signed_op = (bus.in_mdop == 3'd1) || (bus.in_mdop == 3'd3);
    assign is_div_in = (bus.in_mdop == 3'd3) || (bus.in_mdop == 3'd4);
    assign sa        = signed_op & fa[XLEN-1];
    assign sb        = signed_op & fb[XLEN-1];
    assign mdu_busy  = (state_q != S_IDLE);

    // One shared register pair: {acc,qr} is the product for multiply and {remainder,quotient} for divide.
    assign sum    = {1'b0, acc_q} + {1'b0, (qr_q[0] ? b_q : {XLEN{1'b0}})};
    assign rem_sh = {acc_q, qr_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, b_q};

    always_comb begin
        prod_fix = neg_lo_q ? -{acc_q, qr_q} : {acc_q, qr_q};
        if (!is_div_q) begin
            fin_hi = prod_fix[2*XLEN-1:XLEN];
            fin_lo = prod_fix[XLEN-1:0];
        end else if (dz_q) begin
            fin_hi = dvd_q;
            fin_lo = {XLEN{1'b1}};
        end else begin
            fin_hi = neg_hi_q ? -acc_q : acc_q;
            fin_lo = neg_lo_q ? -qr_q : qr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        hilo_wr   = 1'b0;
        done_emit = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_mdu) state_d = S_RUN;
                S_RUN:  if (count_q == CW'(1)) state_d = S_DONE;
                S_DONE: begin
                    hilo_wr = 1'b1;
                    if (!bus.out_valid || bus.out_ready) begin
                        done_emit = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            acc_q    <= '0;
            qr_q     <= '0;
            b_q      <= '0;
            dvd_q    <= '0;
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            dz_q     <= 1'b0;
        end else if (start_mdu) begin
            count_q  <= CW'(XLEN);
            acc_q    <= '0;
            qr_q     <= sa ? -fa : fa;
            b_q      <= sb ? -fb : fb;
            dvd_q    <= fa;
            is_div_q <= is_div_in;
            neg_lo_q <= sa ^ sb;
            neg_hi_q <= is_div_in ? sa : (sa ^ sb);
            dz_q     <= is_div_in && (fb == '0);
        end else if (state_q == S_RUN) begin
            count_q <= count_q - CW'(1);
            if (!is_div_q) begin
                acc_q <= sum[XLEN:1];
                qr_q  <= {sum[0], qr_q[XLEN-1:1]};
            end else if (!diff[XLEN]) begin
                acc_q <= diff[XLEN-1:0];
                qr_q  <= {qr_q[XLEN-2:0], 1'b1};
            end else begin
                acc_q <= rem_sh[XLEN-1:0];
                qr_q  <= {qr_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_wr) begin
            hi_q <= fin_hi;
            lo_q <= fin_lo;
        end else if (mt_acc) begin
            if (bus.in_imm[0]) hi_q <= fa;
            else               lo_q <= fa;
        end
    end

    assign ex_result   = (bus.in_mdop == 3'd5) ? hi_q :
                         (bus.in_mdop == 3'd6) ? lo_q : alu_out;
    assign ex_regwrite = bus.in_regwrite && (bus.in_mdop != 3'd7);
    assign done_result = fin_lo;
`else
    logic unused_mdop;

    assign unused_mdop = ^bus.in_mdop;
    assign start_mdu   = 1'b0;
    assign done_emit   = 1'b0;
    assign mdu_busy    = 1'b0;
    assign ex_result   = alu_out;
    assign ex_regwrite = bus.in_regwrite;
    assign done_result = '0;
`endif

    // MDU tokens carry no side effects downstream: only the LO value rides along as the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_regwrite <= 1'b0;
            bus.out_memread  <= 1'b0;
            bus.out_memwrite <= 1'b0;
            bus.out_memtoreg <= 1'b0;
            bus.out_wa       <= '0;
            bus.out_result   <= '0;
            bus.out_wdata    <= '0;
            bus.out_loadtype <= '0;
            bus.out_savetype <= '0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept && !start_mdu) begin
            bus.out_valid    <= 1'b1;
            bus.out_regwrite <= ex_regwrite;
            bus.out_memread  <= bus.in_memread;
            bus.out_memwrite <= bus.in_memwrite;
            bus.out_memtoreg <= bus.in_memtoreg;
            bus.out_wa       <= bus.in_regdst ? bus.in_rd : bus.in_rt;
            bus.out_result   <= ex_result;
            bus.out_wdata    <= fb;
            bus.out_loadtype <= bus.in_loadtype;
            bus.out_savetype <= bus.in_savetype;
        end else if (done_emit) begin
            bus.out_valid    <= 1'b1;
            bus.out_regwrite <= 1'b0;
            bus.out_memread  <= 1'b0;
            bus.out_memwrite <= 1'b0;
            bus.out_memtoreg <= 1'b0;
            bus.out_wa       <= '0;
            bus.out_result   <= done_result;
            bus.out_wdata    <= '0;
            bus.out_loadtype <= '0;
            bus.out_savetype <= '0;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb/tb_ex_stage_mdu.sv - directed self-checking bench for ex_stage_mdu
module tb_ex_stage_mdu;
    logic        clk;
    logic        rst_n;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] wb_data;
    logic        flush;
    logic        mdu_busy;
    int          total, bad;

    ex_stage_mdu_if #(.XLEN(32), .RAW(5), .AOPW(5)) bus ();

    ex_stage_mdu #(.XLEN(32), .RAW(5), .AOPW(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .fwd_a   (fwd_a),
        .fwd_b   (fwd_b),
        .wb_data (wb_data),
        .flush   (flush),
        .mdu_busy(mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task step;
        @(posedge clk);
        #1;
    endtask

    task clear_in;
        bus.in_valid    = 1'b0;
        bus.in_rd1      = '0;
        bus.in_rd2      = '0;
        bus.in_rt       = '0;
        bus.in_rd       = '0;
        bus.in_shamt    = '0;
        bus.in_imm      = '0;
        bus.in_regdst   = 1'b0;
        bus.in_alusrca  = 1'b0;
        bus.in_alusrcb  = 1'b0;
        bus.in_regwrite = 1'b0;
        bus.in_memread  = 1'b0;
        bus.in_memwrite = 1'b0;
        bus.in_memtoreg = 1'b0;
        bus.in_loadtype = '0;
        bus.in_savetype = '0;
        bus.in_aluop    = '0;
        bus.in_mdop     = '0;
        fwd_a           = 2'b00;
        fwd_b           = 2'b00;
        wb_data         = '0;
    endtask

    task test_reset;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.out_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.out_result); end
        total++; if (bus.out_wa !== 5'h0) begin bad++; $display("FAIL reset_wa got=%h want=0", bus.out_wa); end
        total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", mdu_busy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus.in_ready); end
    endtask

    task test_alu_add;
        clear_in();
        bus.in_valid = 1'b1; bus.in_rd1 = 32'd5; bus.in_rd2 = 32'd7;
        bus.in_regdst = 1'b1; bus.in_rd = 5'd3; bus.in_rt = 5'd9; bus.in_regwrite = 1'b1;
        step();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b want=1", bus.out_valid); end
        total++; if (bus.out_result !== 32'd12) begin bad++; $display("FAIL add_result got=%0d want=12", bus.out_result); end
        total++; if (bus.out_wa !== 5'd3) begin bad++; $display("FAIL add_wa got=%0d want=3", bus.out_wa); end
        total++; if (bus.out_regwrite !== 1'b1) begin bad++; $display("FAIL add_regwrite got=%0b want=1", bus.out_regwrite); end
    endtask

    task test_back_to_back;
        clear_in();
        bus.in_valid = 1'b1; bus.in_rd1 = 32'd99; fwd_a = 2'b10;
        bus.in_alusrcb = 1'b1; bus.in_imm = 32'd1; bus.in_rt = 5'd4;
        step();
        total++; if (bus.out_result !== 32'd13) begin bad++; $display("FAIL fwd_ex_result got=%0d want=13", bus.out_result); end
        total++; if (bus.out_wa !== 5'd4) begin bad++; $display("FAIL fwd_ex_wa got=%0d want=4", bus.out_wa); end
        clear_in();
        bus.in_valid = 1'b1; bus.in_rd1 = 32'd1; bus.in_rd2 = 32'd77;
        fwd_b = 2'b01; wb_data = 32'h100; bus.in_memwrite = 1'b1;
        step();
        total++; if (bus.out_wdata !== 32'h100) begin bad++; $display("FAIL fwd_wb_wdata got=%h want=100", bus.out_wdata); end
        total++; if (bus.out_result !== 32'h101) begin bad++; $display("FAIL fwd_wb_result got=%h want=101", bus.out_result); end
        total++; if (bus.out_memwrite !== 1'b1) begin bad++; $display("FAIL fwd_wb_memwrite got=%0b want=1", bus.out_memwrite); end
        clear_in();
        step();
    endtask

    task test_backpressure;
        clear_in();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_rd1 = 32'd20; bus.in_rd2 = 32'd22;
        step();
        total++; if (bus.out_result !== 32'd42) begin bad++; $display("FAIL bp_first got=%0d want=42", bus.out_result); end
        bus.in_rd1 = 32'd1; bus.in_rd2 = 32'd2;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_%0d got=%0b want=0", i, bus.in_ready); end
            total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd42) begin
                bad++; $display("FAIL bp_hold_%0d got=%0b/%0d want=1/42", i, bus.out_valid, bus.out_result);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b want=1", bus.in_ready); end
        step();
        total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd3) begin
            bad++; $display("FAIL bp_next got=%0b/%0d want=1/3", bus.out_valid, bus.out_result);
        end
        clear_in();
        step();
    endtask

    task test_flush_alu;
        clear_in();
        bus.in_valid = 1'b1; bus.in_rd1 = 32'd50; bus.in_rd2 = 32'd50;
        step();
        flush = 1'b1; bus.in_rd1 = 32'd8;
        step();
        flush = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.out_result !== 32'd100) begin bad++; $display("FAIL flush_result got=%0d want=100", bus.out_result); end
        clear_in();
        step();
    endtask

`ifdef EX_MDU_EN
    task run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cycles);
        clear_in();
        bus.in_valid = 1'b1; bus.in_mdop = op; bus.in_rd1 = a; bus.in_rd2 = b;
        step();
        clear_in();
        cycles = 0;
        while (mdu_busy && cycles < 100) begin
            cycles++;
            step();
        end
    endtask

    task read_hilo(input logic [2:0] op, output logic [31:0] v);
        clear_in();
        bus.in_valid = 1'b1; bus.in_mdop = op; bus.in_regwrite = 1'b1;
        step();
        v = bus.out_result;
        clear_in();
    endtask

    task test_mult;
        int          cyc;
        logic [31:0] v;
        run_mdu(3'd1, 32'hFFFF_FFFD, 32'd4, cyc);
        total++; if (cyc !== 33) begin bad++; $display("FAIL mult_busy got=%0d want=33", cyc); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_regwrite !== 1'b0) begin
            bad++; $display("FAIL mult_token got=%0b/%0b want=1/0", bus.out_valid, bus.out_regwrite);
        end
        read_hilo(3'd6, v);
        total++; if (v !== 32'hFFFF_FFF4) begin bad++; $display("FAIL mult_lo got=%h want=fffffff4", v); end
        read_hilo(3'd5, v);
        total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", v); end
    endtask

    task test_div;
        int          cyc;
        logic [31:0] v;
        run_mdu(3'd3, 32'hFFFF_FFF9, 32'd2, cyc);
        read_hilo(3'd6, v);
        total++; if (v !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", v); end
        read_hilo(3'd5, v);
        total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", v); end
        run_mdu(3'd4, 32'd10, 32'd0, cyc);
        read_hilo(3'd6, v);
        total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_lo got=%h want=ffffffff", v); end
        read_hilo(3'd5, v);
        total++; if (v !== 32'd10) begin bad++; $display("FAIL divz_hi got=%h want=a", v); end
        run_mdu(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        read_hilo(3'd6, v);
        total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL divmin_lo got=%h want=80000000", v); end
        read_hilo(3'd5, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL divmin_hi got=%h want=0", v); end
    endtask

    task test_flush_mdu;
        logic [31:0] v;
        clear_in();
        bus.in_valid = 1'b1; bus.in_mdop = 3'd3; bus.in_rd1 = 32'd100; bus.in_rd2 = 32'd7;
        step();
        clear_in();
        for (int i = 0; i < 8; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (mdu_busy !== 1'b0) begin bad++; $display("FAIL mflush_busy got=%0b want=0", mdu_busy); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mflush_valid got=%0b want=0", bus.out_valid); end
        for (int i = 0; i < 40; i++) step();
        read_hilo(3'd5, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL mflush_hi got=%h want=0", v); end
        read_hilo(3'd6, v);
        total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL mflush_lo got=%h want=80000000", v); end
        clear_in();
        bus.in_valid = 1'b1; bus.in_mdop = 3'd7; bus.in_rd1 = 32'h55; bus.in_imm = 32'd1; bus.in_regwrite = 1'b1;
        step();
        total++; if (bus.out_regwrite !== 1'b0) begin bad++; $display("FAIL mthi_regwrite got=%0b want=0", bus.out_regwrite); end
        read_hilo(3'd5, v);
        total++; if (v !== 32'h55) begin bad++; $display("FAIL mthi_hi got=%h want=55", v); end
        step();
    endtask
`else
    task test_mult_as_alu;
        clear_in();
        bus.in_valid = 1'b1; bus.in_mdop = 3'd1; bus.in_rd1 = 32'hFFFF_FFFD; bus.in_rd2 = 32'd4;
        bus.in_regwrite = 1'b1;
        step();
        clear_in();
        total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd1) begin
            bad++; $display("FAIL nomdu_mult got=%0b/%h want=1/1", bus.out_valid, bus.out_result);
        end
        total++; if (mdu_busy !== 1'b0 || bus.out_regwrite !== 1'b1) begin
            bad++; $display("FAIL nomdu_busy got=%0b/%0b want=0/1", mdu_busy, bus.out_regwrite);
        end
        step();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        clear_in();
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_alu_add();
        test_back_to_back();
        test_backpressure();
        test_flush_alu();
`ifdef EX_MDU_EN
        test_mult();
        test_div();
        test_flush_mdu();
`else
        test_mult_as_alu();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
